// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls, branch
// flushes, data-memory waits, a memory-timeout watchdog and perf counters.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MEM_WAIT
  } state_t;

  state_t state, state_next;

  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              stall_inc;
  logic              flush_inc;

  // A load whose destination is x0 never produces a value worth waiting for.
  assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((use_rs1_i && (RS1addr_i == IDEX_RDaddr_i)) ||
                     (use_rs2_i && (RS2addr_i == IDEX_RDaddr_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    memwb_bubble_o = 1'b0;
    mem_stall      = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    unique case (state)
      INIT: begin
        pc_write_o     = 1'b0;
        ifid_flush_o   = 1'b1;
        idex_bubble_o  = 1'b1;
        memwb_bubble_o = 1'b1;
        if (init_cnt == INIT_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (dmem_busy_i) begin
          mem_stall = 1'b1;
        end else if (load_use) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          stall_inc     = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          flush_inc    = 1'b1;
        end
      end
      MEM_WAIT: begin
        // With busy dropped the MEM access completes on default controls.
        if (dmem_busy_i) begin
          mem_stall = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = INIT;
    endcase

    if (mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
      stall_inc      = 1'b1;
      state_next     = MEM_WAIT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + INIT_W'(1);
    end else begin
      init_cnt <= '0;
    end
  end

  // Watchdog: wait counter saturates at the limit; the error flag is sticky.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt      <= '0;
      timeout_err_o <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wait_cnt >= WAIT_LAST) begin
        timeout_err_o <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl, built with a short watchdog and
// narrow counters so timeout and saturation are reachable quickly.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble
  localparam logic [6:0] C_DEF  = 7'b1101010;
  localparam logic [6:0] C_INIT = 7'b0111111;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111010;
  localparam logic [6:0] C_MEM  = 7'b0000001;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       RS1addr_i, RS2addr_i, IDEX_RDaddr_i;
  logic             use_rs1_i, use_rs2_i, IDEX_MemRead_i, branch_taken_i, dmem_busy_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic             idex_bubble_o, exmem_write_o, memwb_bubble_o, timeout_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [6:0]       ctrl;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
    .branch_taken_i(branch_taken_i), .dmem_busy_i(dmem_busy_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_write_o(idex_write_o), .idex_bubble_o(idex_bubble_o),
    .exmem_write_o(exmem_write_o), .memwb_bubble_o(memwb_bubble_o),
    .timeout_err_o(timeout_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                 idex_bubble_o, exmem_write_o, memwb_bubble_o};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic br, input logic busy);
    RS1addr_i      = rs1;
    RS2addr_i      = rs2;
    use_rs1_i      = u1;
    use_rs2_i      = u2;
    IDEX_MemRead_i = mr;
    IDEX_RDaddr_i  = rd;
    branch_taken_i = br;
    dmem_busy_i    = busy;
  endtask

  // Check this cycle's Mealy controls mid-cycle, then advance past the edge.
  task automatic runCycle(input string tag, input logic [6:0] exp_ctrl);
    @(negedge clk_i);
    checkOutput(tag, 32'(ctrl), 32'(exp_ctrl));
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkCounters(input string tag, input int exp_stall, input int exp_flush);
    checkOutput({tag, "_stall"}, 32'(stall_cnt_o), 32'(exp_stall));
    checkOutput({tag, "_flush"}, 32'(flush_cnt_o), 32'(exp_flush));
  endtask

  task automatic resetAndInit();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    runCycle("init1", C_INIT);
    runCycle("init2", C_INIT);
  endtask

  initial begin
    int exp_stall;
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("rst_ctrl", 32'(ctrl), 32'(C_INIT));
    checkOutput("rst_err", 32'(timeout_err_o), 32'd0);
    checkCounters("rst", 0, 0);

    // INIT holds for exactly two cycles after release.
    rst_i = 1'b1;
    runCycle("init1", C_INIT);
    runCycle("init2", C_INIT);
    runCycle("run_idle", C_DEF);
    checkCounters("after_init", 0, 0);

    // Load-use on rs2, then the bubble clears MemRead.
    applyStimulus(0, 5, 0, 1, 1, 5, 0, 0);
    runCycle("lu_rs2", C_LU);
    checkCounters("lu_rs2", 1, 0);
    applyStimulus(0, 5, 0, 1, 0, 5, 0, 0);
    runCycle("lu_clear", C_DEF);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    runCycle("lu_x0", C_DEF);
    checkCounters("lu_x0", 1, 0);
    applyStimulus(7, 0, 1, 0, 1, 7, 0, 0);
    runCycle("lu_rs1", C_LU);
    checkCounters("lu_rs1", 2, 0);
    applyStimulus(7, 0, 0, 0, 1, 7, 0, 0);
    runCycle("lu_unused", C_DEF);

    // Branch alone flushes; branch under load-use only stalls.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    runCycle("br", C_BR);
    checkCounters("br", 2, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("br_done", C_DEF);
    applyStimulus(0, 5, 0, 1, 1, 5, 1, 0);
    runCycle("br_lu", C_LU);
    checkCounters("br_lu", 3, 1);

    // Memory wait dominates load-use and branch for three cycles.
    resetAndInit();
    applyStimulus(0, 5, 0, 1, 1, 5, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      runCycle("mem_busy", C_MEM);
      checkOutput("mem_stall_cnt", 32'(stall_cnt_o), 32'(i));
    end
    checkCounters("mem3", 3, 0);
    checkOutput("mem3_err", 32'(timeout_err_o), 32'd0);
    applyStimulus(0, 5, 0, 1, 1, 5, 1, 0);
    runCycle("mem_done", C_DEF);
    runCycle("mem_rerun_lu", C_LU);
    checkCounters("mem_rerun", 4, 0);

    // Watchdog sets on the fourth consecutive busy cycle and stays set.
    resetAndInit();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      runCycle("tmo_busy", C_MEM);
      checkOutput("tmo_err", 32'(timeout_err_o), (i >= 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("tmo_release", C_DEF);
    runCycle("tmo_idle", C_DEF);
    checkOutput("tmo_sticky", 32'(timeout_err_o), 32'd1);

    // Asynchronous reset in the middle of a memory wait.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    runCycle("pre_rst_busy", C_MEM);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 32'(ctrl), 32'(C_INIT));
    checkOutput("midrst_err", 32'(timeout_err_o), 32'd0);
    checkCounters("midrst", 0, 0);

    // Stall counter saturates at 15 over 20 load-use stalls.
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle("sat_init1", C_INIT);
    runCycle("sat_init2", C_INIT);
    exp_stall = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(9, 0, 1, 0, 1, 9, 0, 0);
      runCycle("sat_lu", C_LU);
      exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
      checkOutput("sat_cnt", 32'(stall_cnt_o), 32'(exp_stall));
      applyStimulus(9, 0, 1, 0, 0, 9, 0, 0);
      runCycle("sat_gap", C_DEF);
    end
    checkOutput("sat_final", 32'(stall_cnt_o), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
